// File: rtl/sm83_int_ctrl_if.sv
// Bus bundle between the sm83 control unit (master) and the interrupt
// controller (slave): register access, IME strobes, instruction boundary
// strobe and the dispatch handshake.
interface sm83_int_ctrl_if #(
  parameter int NUM_IRQS  = 8,
  parameter int WORD_SIZE = 8
);
  logic [NUM_IRQS-1:0]  irq;
  logic                 if_we;
  logic                 ie_we;
  logic [WORD_SIZE-1:0] din;
  logic [WORD_SIZE-1:0] if_dout;
  logic [WORD_SIZE-1:0] ie_dout;
  logic                 ei;
  logic                 di;
  logic                 reti;
  logic                 inst_end;
  logic                 int_pending;
  logic                 wake;
  logic                 entry_start;
  logic                 vec_rd;
  logic [WORD_SIZE-1:0] vector;
  logic [NUM_IRQS-1:0]  iack;
  logic                 busy;

  modport master (
    output irq, if_we, ie_we, din, ei, di, reti, inst_end, entry_start, vec_rd,
    input  if_dout, ie_dout, int_pending, wake, vector, iack, busy
  );

  modport slave (
    input  irq, if_we, ie_we, din, ei, di, reti, inst_end, entry_start, vec_rd,
    output if_dout, ie_dout, int_pending, wake, vector, iack, busy
  );
endinterface

// File: rtl/sm83_int_ctrl.sv
// sm83 interrupt controller: IF/IE/IME state with delayed EI, fixed-priority
// arbitration (index 0 highest), dispatch handshake with cancel-to-zero and
// HALT wake request.
// Optional macro SM83_INT_EDGE_EN: requests are rising edges of irq instead
// of levels.
module sm83_int_ctrl #(
  parameter int NUM_IRQS   = 8,
  parameter int WORD_SIZE  = 8,
  parameter int VEC_BASE   = 'h40,
  parameter int VEC_STRIDE = 8
) (
  input  logic             clk,
  input  logic             nreset,
  sm83_int_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, VEC = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [NUM_IRQS-1:0]  if_r, ie_r, req, din_n, ie_eff, pend, ack_oh, clr;
  logic [WORD_SIZE-1:0] vec_sel, vector_r, if_rd, ie_rd;
  logic [NUM_IRQS-1:0]  iack_r;
  logic                 ime, ei_armed, ei_skip;
  logic                 entry_go, vec_go, busy_o;
  logic                 unused_din;

  // din bits beyond the source count carry nothing
  assign unused_din = ^bus.din;

  // Map the data bus onto the source vector and back for reads. Unused
  // IF bits read as 1 (as on the original part); unused IE bits read 0.
  for (genvar g = 0; g < NUM_IRQS; g++) begin : g_din
    if (g < WORD_SIZE) begin : g_on
      assign din_n[g] = bus.din[g];
    end else begin : g_off
      assign din_n[g] = 1'b0;
    end
  end

  for (genvar g = 0; g < WORD_SIZE; g++) begin : g_rd
    if (g < NUM_IRQS) begin : g_on
      assign if_rd[g] = if_r[g];
      assign ie_rd[g] = ie_r[g];
    end else begin : g_off
      assign if_rd[g] = 1'b1;
      assign ie_rd[g] = 1'b0;
    end
  end

`ifdef SM83_INT_EDGE_EN
  logic [NUM_IRQS-1:0] irq_q;

  // Previous irq sample for rising-edge detection
  always_ff @(posedge clk) begin
    if (!nreset) irq_q <= '0;
    else         irq_q <= bus.irq;
  end

  assign req = bus.irq & ~irq_q;
`else
  assign req = bus.irq;
`endif

  assign entry_go = (state == IDLE)  && bus.entry_start;
  assign vec_go   = (state == ENTRY) && bus.vec_rd;

  // An IE write coinciding with the final push is already visible to
  // arbitration, which lets the pushed IE cancel the dispatch.
  assign ie_eff = bus.ie_we ? din_n : ie_r;
  assign pend   = if_r & ie_eff;
  assign clr    = vec_go ? ack_oh : '0;

  // Fixed-priority pick: lowest set index wins, zero vector when nothing left
  always_comb begin
    ack_oh  = '0;
    vec_sel = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        ack_oh  = NUM_IRQS'(1) << i;
        vec_sel = WORD_SIZE'(VEC_BASE + i * VEC_STRIDE);
      end
    end
  end

  // IF: set beats ack-clear beats software write, per bit
  always_ff @(posedge clk) begin
    if (!nreset) if_r <= '0;
    else         if_r <= req | (~clr & (bus.if_we ? din_n : if_r));
  end

  // IE: software write only
  always_ff @(posedge clk) begin
    if (!nreset)        ie_r <= '0;
    else if (bus.ie_we) ie_r <= din_n;
  end

  // IME with delayed EI: ei_skip marks that EI's own boundary is still to
  // come, so IME rises on the boundary after it. A second EI while armed
  // is ignored.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ime      <= 1'b0;
      ei_armed <= 1'b0;
      ei_skip  <= 1'b0;
    end else if (entry_go || bus.di) begin
      ime      <= 1'b0;
      ei_armed <= 1'b0;
      ei_skip  <= 1'b0;
    end else begin
      if (bus.reti) ime <= 1'b1;
      if (ei_armed) begin
        if (bus.inst_end) begin
          if (ei_skip) begin
            ei_skip <= 1'b0;
          end else begin
            ime      <= 1'b1;
            ei_armed <= 1'b0;
          end
        end
      end else if (bus.ei) begin
        ei_armed <= 1'b1;
        ei_skip  <= ~bus.inst_end;
      end
    end
  end

  // Dispatch FSM state register
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Dispatch FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.entry_start) state_nxt = ENTRY;
      ENTRY:   if (bus.vec_rd)      state_nxt = VEC;
      VEC:                          state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Dispatch FSM outputs
  always_comb begin
    busy_o = (state == ENTRY) || (state == VEC);
  end

  // Vector held until the next vec_rd; iack is a one-cycle pulse in VEC
  always_ff @(posedge clk) begin
    if (!nreset) begin
      vector_r <= '0;
      iack_r   <= '0;
    end else begin
      iack_r <= clr;
      if (vec_go) vector_r <= vec_sel;
    end
  end

  assign bus.if_dout     = if_rd;
  assign bus.ie_dout     = ie_rd;
  assign bus.wake        = |(if_r & ie_r);
  assign bus.int_pending = ime & (|(if_r & ie_r));
  assign bus.vector      = vector_r;
  assign bus.iack        = iack_r;
  assign bus.busy        = busy_o;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Bench for sm83_int_ctrl: dispatch vector table, hand sequences for IME,
// cancel, wake and a 12-source variant, then random traffic against a
// behavioural model.
module tb_sm83_int_ctrl;
  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sm83_int_ctrl_if #(.NUM_IRQS(8),  .WORD_SIZE(8))  bus0 ();
  sm83_int_ctrl_if #(.NUM_IRQS(12), .WORD_SIZE(16)) bus1 ();

  sm83_int_ctrl #(.NUM_IRQS(8), .WORD_SIZE(8), .VEC_BASE('h40), .VEC_STRIDE(8))
    u0 (.clk(clk), .nreset(nreset), .bus(bus0));
  sm83_int_ctrl #(.NUM_IRQS(12), .WORD_SIZE(16), .VEC_BASE('h40), .VEC_STRIDE(4))
    u1 (.clk(clk), .nreset(nreset), .bus(bus1));

  typedef struct {
    logic [7:0] irq;
    logic [7:0] ie;
    logic [7:0] vec;
    logic [7:0] iack;
    logic [7:0] if_after;
  } dvec_t;

  dvec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic quiet0();
    bus0.irq = '0; bus0.if_we = 0; bus0.ie_we = 0; bus0.din = '0;
    bus0.ei = 0; bus0.di = 0; bus0.reti = 0; bus0.inst_end = 0;
    bus0.entry_start = 0; bus0.vec_rd = 0;
  endtask

  task automatic quiet1();
    bus1.irq = '0; bus1.if_we = 0; bus1.ie_we = 0; bus1.din = '0;
    bus1.ei = 0; bus1.di = 0; bus1.reti = 0; bus1.inst_end = 0;
    bus1.entry_start = 0; bus1.vec_rd = 0;
  endtask

  task automatic do_reset();
    quiet0(); quiet1();
    nreset = 0;
    tick(); tick();
    nreset = 1;
  endtask

  // Behavioural model state for the random phase
  logic [7:0] m_if, m_ie, m_vec, m_iack, m_prev;
  logic       m_ime;
  int         m_wait;   // boundaries left before a pending EI takes effect
  int         m_phase;  // 0 idle, 1 waiting for vec_rd, 2 vector cycle

  initial begin
    tbl[0] = '{irq: 8'h04, ie: 8'h1F, vec: 8'h50, iack: 8'h04, if_after: 8'h00};
    tbl[1] = '{irq: 8'h11, ie: 8'h1F, vec: 8'h40, iack: 8'h01, if_after: 8'h10};
    tbl[2] = '{irq: 8'h80, ie: 8'hFF, vec: 8'h78, iack: 8'h80, if_after: 8'h00};
    tbl[3] = '{irq: 8'h0C, ie: 8'h08, vec: 8'h58, iack: 8'h08, if_after: 8'h04};
    tbl[4] = '{irq: 8'h02, ie: 8'h00, vec: 8'h00, iack: 8'h00, if_after: 8'h02};
    tbl[5] = '{irq: 8'hFF, ie: 8'hFE, vec: 8'h48, iack: 8'h02, if_after: 8'hFD};

    do_reset();
    chk("rst_if",    bus0.if_dout, 8'h00);
    chk("rst_ie",    bus0.ie_dout, 8'h00);
    chk("rst_pend",  bus0.int_pending, 1'b0);
    chk("rst_wake",  bus0.wake, 1'b0);
    chk("rst_vec",   bus0.vector, 8'h00);
    chk("rst_iack",  bus0.iack, 8'h00);
    chk("rst_busy",  bus0.busy, 1'b0);
    chk("rst_if1",   bus1.if_dout, 16'hF000);

    // Dispatch table
    for (int r = 0; r < 6; r++) begin
      quiet0();
      bus0.if_we = 1; bus0.din = 8'h00; tick();
      bus0.if_we = 0; bus0.ie_we = 1; bus0.din = tbl[r].ie; bus0.irq = tbl[r].irq; tick();
      quiet0(); bus0.entry_start = 1; tick();
      chk($sformatf("t%0d_busy_entry", r), bus0.busy, 1'b1);
      quiet0(); bus0.vec_rd = 1; tick();
      chk($sformatf("t%0d_vec", r),  bus0.vector, tbl[r].vec);
      chk($sformatf("t%0d_iack", r), bus0.iack, tbl[r].iack);
      chk($sformatf("t%0d_busy_vec", r), bus0.busy, 1'b1);
      quiet0(); tick();
      chk($sformatf("t%0d_iack_off", r), bus0.iack, 8'h00);
      chk($sformatf("t%0d_idle", r),     bus0.busy, 1'b0);
      chk($sformatf("t%0d_if", r),       bus0.if_dout, tbl[r].if_after);
      chk($sformatf("t%0d_vec_hold", r), bus0.vector, tbl[r].vec);
    end

    // Full dispatch with IME via RETI
    do_reset();
    bus0.ie_we = 1; bus0.din = 8'h1F; tick();
    quiet0(); bus0.irq = 8'h04; bus0.reti = 1; tick();
    quiet0(); bus0.inst_end = 1; tick();
    chk("b_pend", bus0.int_pending, 1'b1);
    chk("b_wake", bus0.wake, 1'b1);
    quiet0(); bus0.entry_start = 1; tick();
    chk("b_ime_clr", bus0.int_pending, 1'b0);
    quiet0(); bus0.vec_rd = 1; tick();
    chk("b_vec",  bus0.vector, 8'h50);
    chk("b_iack", bus0.iack, 8'h04);
    chk("b_if",   bus0.if_dout, 8'h00);
    quiet0(); tick();
    chk("b_iack_off", bus0.iack, 8'h00);

    // IE pushed to zero on the final push cancels the dispatch
    bus0.irq = 8'h02; tick();
    quiet0(); bus0.entry_start = 1; tick();
    quiet0(); bus0.vec_rd = 1; bus0.ie_we = 1; bus0.din = 8'h00; tick();
    chk("c_vec",  bus0.vector, 8'h00);
    chk("c_iack", bus0.iack, 8'h00);
    chk("c_ie",   bus0.ie_dout, 8'h00);
    quiet0(); tick();
    chk("c_if",   bus0.if_dout, 8'h02);
    chk("c_busy", bus0.busy, 1'b0);

    // Delayed EI, and DI cancelling an armed EI
    bus0.ie_we = 1; bus0.din = 8'h02; tick();
    quiet0(); bus0.ei = 1; tick();
    quiet0(); bus0.inst_end = 1; tick();
    chk("d_ei_first", bus0.int_pending, 1'b0);
    tick();
    chk("d_ei_second", bus0.int_pending, 1'b1);
    quiet0(); bus0.di = 1; tick();
    chk("d_di", bus0.int_pending, 1'b0);
    quiet0(); bus0.ei = 1; tick();
    quiet0(); bus0.inst_end = 1; tick();
    quiet0(); bus0.di = 1; tick();
    quiet0(); bus0.inst_end = 1; tick();
    chk("d_ei_cancel", bus0.int_pending, 1'b0);
    quiet0();

    // HALT wake without IME
    bus0.if_we = 1; bus0.din = 8'h00; tick();
    quiet0(); bus0.ie_we = 1; bus0.din = 8'h04; bus0.irq = 8'h04; tick();
    chk("e_wake", bus0.wake, 1'b1);
    chk("e_pend", bus0.int_pending, 1'b0);
    quiet0(); bus0.vec_rd = 1; tick();
    chk("e_vecrd_idle_busy", bus0.busy, 1'b0);
    chk("e_vecrd_idle_if",   bus0.if_dout, 8'h04);
    quiet0(); tick();
    chk("e_vecrd_idle_iack", bus0.iack, 8'h00);

    // 12-source instance, stride 4
    bus1.ie_we = 1; bus1.din = 16'h0800; bus1.irq = 12'h800; tick();
    quiet1(); bus1.entry_start = 1; tick();
    quiet1(); bus1.vec_rd = 1; tick();
    chk("f_vec",  bus1.vector, 16'h006C);
    chk("f_iack", bus1.iack, 12'h800);
    quiet1(); tick();
    chk("f_if", bus1.if_dout, 16'hF000);

    // Held request vs software clear of IF
    do_reset();
    bus0.irq = 8'h08; tick();
    chk("g_set", bus0.if_dout[3], 1'b1);
    bus0.if_we = 1; bus0.din = 8'h00; tick();
    bus0.if_we = 0;
`ifdef SM83_INT_EDGE_EN
    chk("g_clr", bus0.if_dout[3], 1'b0);
    tick();
    chk("g_stay", bus0.if_dout[3], 1'b0);
`else
    chk("g_clr", bus0.if_dout[3], 1'b1);
    tick();
    chk("g_stay", bus0.if_dout[3], 1'b1);
`endif
    quiet0();

    // Random traffic against the model
    do_reset();
    m_if = 0; m_ie = 0; m_vec = 0; m_iack = 0; m_prev = 0;
    m_ime = 0; m_wait = 0; m_phase = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] req, ie_e, p, ack, nif;
      logic       ack_any;
      nreset           = ($urandom_range(0, 99) != 0);
      bus0.irq         = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      bus0.din         = 8'($urandom);
      bus0.if_we       = ($urandom_range(0, 7) == 0);
      bus0.ie_we       = ($urandom_range(0, 7) == 0);
      bus0.ei          = ($urandom_range(0, 9) == 0);
      bus0.di          = ($urandom_range(0, 15) == 0);
      bus0.reti        = ($urandom_range(0, 19) == 0);
      bus0.inst_end    = ($urandom_range(0, 3) == 0);
      bus0.entry_start = ($urandom_range(0, 3) == 0);
      bus0.vec_rd      = ($urandom_range(0, 2) == 0);

      if (!nreset) begin
        m_if = 0; m_ie = 0; m_vec = 0; m_iack = 0; m_prev = 0;
        m_ime = 0; m_wait = 0; m_phase = 0;
      end else begin
`ifdef SM83_INT_EDGE_EN
        req = bus0.irq & ~m_prev;
`else
        req = bus0.irq;
`endif
        m_prev  = bus0.irq;
        ie_e    = bus0.ie_we ? bus0.din : m_ie;
        p       = m_if & ie_e;
        ack     = 0;
        ack_any = 0;
        if (m_phase == 1 && bus0.vec_rd) begin
          m_vec = 0;
          for (int b = 0; b < 8; b++) begin
            if (!ack_any && p[b]) begin
              ack_any = 1;
              ack[b]  = 1'b1;
              m_vec   = 8'((64 + b * 8) % 256);
            end
          end
        end
        m_iack = ack;
        for (int b = 0; b < 8; b++)
          nif[b] = req[b] ? 1'b1 : ack[b] ? 1'b0 : bus0.if_we ? bus0.din[b] : m_if[b];
        m_if = nif;
        if (bus0.ie_we) m_ie = bus0.din;
        if ((m_phase == 0 && bus0.entry_start) || bus0.di) begin
          m_ime = 0; m_wait = 0;
        end else begin
          if (bus0.reti) m_ime = 1;
          if (m_wait > 0) begin
            if (bus0.inst_end) begin
              m_wait--;
              if (m_wait == 0) m_ime = 1;
            end
          end else if (bus0.ei) begin
            m_wait = bus0.inst_end ? 1 : 2;
          end
        end
        case (m_phase)
          0: if (bus0.entry_start) m_phase = 1;
          1: if (bus0.vec_rd)      m_phase = 2;
          default:                 m_phase = 0;
        endcase
      end
      tick();
      chk($sformatf("r%0d_if", c),   bus0.if_dout, m_if);
      chk($sformatf("r%0d_ie", c),   bus0.ie_dout, m_ie);
      chk($sformatf("r%0d_vec", c),  bus0.vector, m_vec);
      chk($sformatf("r%0d_iack", c), bus0.iack, m_iack);
      chk($sformatf("r%0d_busy", c), bus0.busy, (m_phase != 0));
      chk($sformatf("r%0d_wake", c), bus0.wake, ((m_if & m_ie) != 0));
      chk($sformatf("r%0d_pend", c), bus0.int_pending, m_ime && ((m_if & m_ie) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
